// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID self-check sequencer and its compare unit.
package soc_system_sysid_pkg;

  typedef enum logic [1:0] {
    S_RD_ID = 2'd0,
    S_RD_TS = 2'd1,
    S_IDLE  = 2'd2
  } state_e;

  localparam logic SYSID_WORD_ID = 1'b0;
  localparam logic SYSID_WORD_TS = 1'b1;

  localparam int FAIL_CNT_W = 8;
  localparam int SETTLE_W   = 4;

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/soc_system_sysid_cmp.sv
// Settle counter and word compare: waits SETTLE_CYCLES on the selected word, then
// flags sample; the word-0 result is held for the completion cycle of word 1.
module soc_system_sysid_cmp
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS   = 32'h54ACDB4B,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic        word_sel,
  input  logic [31:0] rdata,
  output logic        sample,
  output logic        hit,
  output logic        id_hit_q
);

  logic [SETTLE_W-1:0] cnt_q;

  assign sample = en && (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));
  assign hit    = (rdata == ((word_sel == SYSID_WORD_TS) ? EXPECTED_TS : EXPECTED_ID));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      id_hit_q <= 1'b0;
    end else begin
      if (!en || sample) cnt_q <= '0;
      else               cnt_q <= cnt_q + 1'b1;
      if (sample && (word_sel == SYSID_WORD_ID)) id_hit_q <= hit;
    end
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// System-ID self-check sequencer and host-port arbiter in front of the sysid slave.
// Optional periodic recheck enabled by defining SYSID_CHECK_PERIODIC_EN.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h54ACDB4B,
  parameter int          SETTLE_CYCLES  = 1,
  parameter int          RECHECK_PERIOD = 50000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  avs_address,
  input  logic                  avs_read,
  output logic                  avs_waitrequest,
  output logic [31:0]           avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  sysid_address,
  input  logic [31:0]           sysid_readdata,
  input  logic                  recheck,
  output logic                  check_busy,
  output logic                  check_done,
  output logic                  id_ok,
  output logic                  ts_ok,
  output logic [FAIL_CNT_W-1:0] fail_count
);

  state_e state_q;
  logic   pending_q;
  logic   host_acc;
  logic   start;
  logic   period_hit;
  logic   sample;
  logic   hit;
  logic   id_hit_q;

  assign check_busy      = (state_q != S_IDLE);
  assign avs_waitrequest = (state_q != S_IDLE);
  assign host_acc        = avs_read && (state_q == S_IDLE);

  // The host owns the slave address while idle; the sequencer owns it otherwise.
  always_comb begin
    sysid_address = SYSID_WORD_ID;
    case (state_q)
      S_RD_TS: sysid_address = SYSID_WORD_TS;
      S_IDLE:  sysid_address = avs_address;
      default: sysid_address = SYSID_WORD_ID;
    endcase
  end

  // A host read accepted this cycle always wins over a queued check.
  assign start = (state_q == S_IDLE) && (pending_q || recheck || period_hit) && !host_acc;

  soc_system_sysid_cmp #(
    .EXPECTED_ID  (EXPECTED_ID),
    .EXPECTED_TS  (EXPECTED_TS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_cmp (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state_q != S_IDLE),
    .word_sel(sysid_address),
    .rdata   (sysid_readdata),
    .sample  (sample),
    .hit     (hit),
    .id_hit_q(id_hit_q)
  );

`ifdef SYSID_CHECK_PERIODIC_EN
  logic [31:0] period_q;

  // Held at the reload value while checking, so it restarts on every S_IDLE entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                period_q <= 32'(RECHECK_PERIOD - 1);
    else if (state_q != S_IDLE)  period_q <= 32'(RECHECK_PERIOD - 1);
    else if (period_q != '0)     period_q <= period_q - 1'b1;
  end

  assign period_hit = (state_q == S_IDLE) && (period_q == '0);
`else
  localparam int UNUSED_RECHECK_PERIOD = RECHECK_PERIOD;
  assign period_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_RD_ID;
      pending_q         <= 1'b0;
      check_done        <= 1'b0;
      id_ok             <= 1'b0;
      ts_ok             <= 1'b0;
      fail_count        <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= host_acc;
      if (host_acc) avs_readdata <= sysid_readdata;

      pending_q <= start ? 1'b0 : (pending_q || recheck || period_hit);

      case (state_q)
        S_RD_ID: if (sample) state_q <= S_RD_TS;
        S_RD_TS: begin
          if (sample) begin
            id_ok      <= id_hit_q;
            ts_ok      <= hit;
            check_done <= 1'b1;
            if (!(id_hit_q && hit)) fail_count <= sat_inc(fail_count);
            state_q    <= S_IDLE;
          end
        end
        S_IDLE:  if (start) state_q <= S_RD_ID;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for soc_system_sysid_checker (default build, SETTLE_CYCLES = 1).
module tb_soc_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h54ACDB4B;
  localparam logic [31:0] BAD_TS = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        avs_address;
  logic        avs_read;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        sysid_address;
  logic [31:0] sysid_readdata;
  logic        recheck;
  logic        check_busy;
  logic        check_done;
  logic        id_ok;
  logic        ts_ok;
  logic [7:0]  fail_count;

  logic [31:0] id_val;
  logic [31:0] ts_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // Combinational system-ID slave model.
  assign sysid_readdata = sysid_address ? ts_val : id_val;

  soc_system_sysid_checker dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_waitrequest  (avs_waitrequest),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .sysid_address    (sysid_address),
    .sysid_readdata   (sysid_readdata),
    .recheck          (recheck),
    .check_busy       (check_busy),
    .check_done       (check_done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .fail_count       (fail_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One recheck pulse in S_IDLE, then wait out the two-cycle check.
  task automatic run_check();
    recheck = 1'b1;
    tick();
    recheck = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    32'(check_busy),        32'd1);
    check({tag, "_wait"},    32'(avs_waitrequest),   32'd1);
    check({tag, "_done"},    32'(check_done),        32'd0);
    check({tag, "_id_ok"},   32'(id_ok),             32'd0);
    check({tag, "_ts_ok"},   32'(ts_ok),             32'd0);
    check({tag, "_fails"},   32'(fail_count),        32'd0);
    check({tag, "_valid"},   32'(avs_readdatavalid), 32'd0);
    check({tag, "_rdata"},   avs_readdata,           32'd0);
    check({tag, "_sysaddr"}, 32'(sysid_address),     32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    avs_read    = 1'b0;
    avs_address = 1'b0;
    recheck     = 1'b0;
    id_val      = EXP_ID;
    ts_val      = EXP_TS;
    tick();
    tick();
    check_reset_values("rst");

    // Power-on check: two cycles with SETTLE_CYCLES = 1.
    reset_n = 1'b1;
    tick();
    check("por_busy_c1",    32'(check_busy),    32'd1);
    check("por_sysaddr_c1", 32'(sysid_address), 32'd1);
    tick();
    check("por_busy_c2", 32'(check_busy),      32'd0);
    check("por_wait_c2", 32'(avs_waitrequest), 32'd0);
    check("por_done",    32'(check_done),      32'd1);
    check("por_id_ok",   32'(id_ok),           32'd1);
    check("por_ts_ok",   32'(ts_ok),           32'd1);
    check("por_fails",   32'(fail_count),      32'd0);

    // Back-to-back host reads 0,1,0.
    avs_read    = 1'b1;
    avs_address = 1'b0;
    tick();
    check("b2b_v0", 32'(avs_readdatavalid), 32'd1);
    check("b2b_d0", avs_readdata,           EXP_ID);
    avs_address = 1'b1;
    tick();
    check("b2b_v1", 32'(avs_readdatavalid), 32'd1);
    check("b2b_d1", avs_readdata,           EXP_TS);
    avs_address = 1'b0;
    tick();
    check("b2b_v2", 32'(avs_readdatavalid), 32'd1);
    check("b2b_d2", avs_readdata,           EXP_ID);
    avs_read = 1'b0;
    tick();
    check("b2b_v_off",  32'(avs_readdatavalid), 32'd0);
    check("b2b_d_hold", avs_readdata,           EXP_ID);

    // Host read during a check is stalled until S_IDLE.
    recheck = 1'b1;
    tick();
    recheck     = 1'b0;
    avs_read    = 1'b1;
    avs_address = 1'b1;
    check("stall_busy_rd_id", 32'(check_busy),      32'd1);
    check("stall_wait_rd_id", 32'(avs_waitrequest), 32'd1);
    tick();
    check("stall_wait_rd_ts", 32'(avs_waitrequest),   32'd1);
    check("stall_valid_none", 32'(avs_readdatavalid), 32'd0);
    tick();
    check("stall_wait_idle", 32'(avs_waitrequest),   32'd0);
    check("stall_valid_pre", 32'(avs_readdatavalid), 32'd0);
    tick();
    avs_read = 1'b0;
    check("stall_valid", 32'(avs_readdatavalid), 32'd1);
    check("stall_rdata", avs_readdata,           EXP_TS);

    // Timestamp mismatch, then saturation of fail_count.
    ts_val = BAD_TS;
    run_check();
    check("bad_done",  32'(check_done), 32'd1);
    check("bad_id_ok", 32'(id_ok),      32'd1);
    check("bad_ts_ok", 32'(ts_ok),      32'd0);
    check("bad_fails", 32'(fail_count), 32'd1);
    for (int i = 0; i < 254; i++) run_check();
    check("sat_reach", 32'(fail_count), 32'd255);
    run_check();
    run_check();
    check("sat_hold", 32'(fail_count), 32'd255);

    // Recheck coincident with a host read: read first, check next cycle.
    ts_val      = EXP_TS;
    avs_read    = 1'b1;
    avs_address = 1'b0;
    recheck     = 1'b1;
    tick();
    avs_read = 1'b0;
    recheck  = 1'b0;
    check("coin_valid", 32'(avs_readdatavalid), 32'd1);
    check("coin_rdata", avs_readdata,           EXP_ID);
    check("coin_idle",  32'(check_busy),        32'd0);
    tick();
    check("coin_busy", 32'(check_busy), 32'd1);
    tick();
    tick();
    check("coin_end",   32'(check_busy), 32'd0);
    check("coin_ts_ok", 32'(ts_ok),      32'd1);
    check("coin_fails", 32'(fail_count), 32'd255);

    // Reset drops an in-flight read result.
    avs_read    = 1'b1;
    avs_address = 1'b1;
    tick();
    avs_read = 1'b0;
    check("rrd_valid", 32'(avs_readdatavalid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rrd_valid_drop", 32'(avs_readdatavalid), 32'd0);
    check("rrd_rdata_clr",  avs_readdata,           32'd0);

    // Reset asserted in S_RD_TS.
    reset_n = 1'b1;
    tick();
    check("rts_in_ts", 32'(sysid_address), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("rts");
    reset_n = 1'b1;
    tick();
    tick();
    check("rts_rerun_done", 32'(check_done), 32'd1);
    check("rts_rerun_id",   32'(id_ok),      32'd1);
    check("rts_rerun_ts",   32'(ts_ok),      32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
